// File: rtl/reg_wb_arb.sv
// Writeback arbiter: merges the ALU pipe and a FIFO-buffered memory return path onto one register file write port.
// Latency: ALU results issue 1 cycle after valid; memory results issue at least 2 cycles after the handshake.
// Backpressure: the ALU has none; the memory path drops mem_wb_rdy when the FIFO is full (no same-cycle pop credit).

package reg_file_pkg;
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } reg_file_wr_req_pkt_t;
endpackage

module reg_wb_arb #(
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               alu_wb_vld,
   input  logic [4:0]                         alu_wb_addr,
   input  logic [31:0]                        alu_wb_data,
   input  logic                               mem_wb_vld,
   output logic                               mem_wb_rdy,
   input  logic [4:0]                         mem_wb_addr,
   input  logic [31:0]                        mem_wb_data,
   output logic                               reg_file_wr_req_vld,
   output reg_file_pkg::reg_file_wr_req_pkt_t reg_file_wr_req_pkt,
   output logic [31:0]                        pend_mask,
   output logic                               alu_stall_req
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIM + 1);

   logic [4:0]    fifo_addr [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] starve_cnt;

   logic alu_req;
   logic fifo_empty;
   logic push;
   logic pop;

   // Writes to r0 are architecturally void, so they never request the port or enter the FIFO.
   assign alu_req    = alu_wb_vld && (alu_wb_addr != 5'd0);
   assign fifo_empty = (count == '0);
   assign mem_wb_rdy = (count != CW'(DEPTH));
   assign push       = mem_wb_vld && mem_wb_rdy && (mem_wb_addr != 5'd0);
   assign pop        = !alu_req && !fifo_empty;

   // FIFO storage; contents need no reset because count gates every use.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= mem_wb_addr;
         fifo_data[wr_ptr] <= mem_wb_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Pending mask covers only queued entries; the in-flight output write is bypassed by the register file.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [AW-1:0] offs;
         offs = AW'(i) - rd_ptr;
         if (CW'(offs) < count) pend_mask[fifo_addr[i]] = 1'b1;
      end
   end

   // Output register: ALU has priority, otherwise the FIFO head; packet holds when nothing is selected.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         reg_file_wr_req_vld <= 1'b0;
         reg_file_wr_req_pkt <= '0;
      end else if (alu_req) begin
         reg_file_wr_req_vld      <= 1'b1;
         reg_file_wr_req_pkt.addr <= alu_wb_addr;
         reg_file_wr_req_pkt.data <= alu_wb_data;
      end else if (pop) begin
         reg_file_wr_req_vld      <= 1'b1;
         reg_file_wr_req_pkt.addr <= fifo_addr[rd_ptr];
         reg_file_wr_req_pkt.data <= fifo_data[rd_ptr];
      end else begin
         reg_file_wr_req_vld <= 1'b0;
      end
   end

   // Starvation tracking: count lost arbitrations of a waiting head and request a one-cycle ALU bubble at the limit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt    <= '0;
         alu_stall_req <= 1'b0;
      end else begin
         alu_stall_req <= 1'b0;
         if (fifo_empty || pop) begin
            starve_cnt <= '0;
         end else if (starve_cnt == SW'(STARVE_LIM - 1)) begin
            starve_cnt    <= '0;
            alu_stall_req <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_wb_arb.sv
// Directed self-checking bench for reg_wb_arb.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.

module tb_reg_wb_arb;

   logic        clk;
   logic        resetn;
   logic        alu_wb_vld;
   logic [4:0]  alu_wb_addr;
   logic [31:0] alu_wb_data;
   logic        mem_wb_vld;
   logic        mem_wb_rdy;
   logic [4:0]  mem_wb_addr;
   logic [31:0] mem_wb_data;
   logic        reg_file_wr_req_vld;
   reg_file_pkg::reg_file_wr_req_pkt_t reg_file_wr_req_pkt;
   logic [31:0] pend_mask;
   logic        alu_stall_req;

   int checks   = 0;
   int failures = 0;

   reg_wb_arb #(.DEPTH(4), .STARVE_LIM(8)) dut (
      .clk                 (clk),
      .resetn              (resetn),
      .alu_wb_vld          (alu_wb_vld),
      .alu_wb_addr         (alu_wb_addr),
      .alu_wb_data         (alu_wb_data),
      .mem_wb_vld          (mem_wb_vld),
      .mem_wb_rdy          (mem_wb_rdy),
      .mem_wb_addr         (mem_wb_addr),
      .mem_wb_data         (mem_wb_data),
      .reg_file_wr_req_vld (reg_file_wr_req_vld),
      .reg_file_wr_req_pkt (reg_file_wr_req_pkt),
      .pend_mask           (pend_mask),
      .alu_stall_req       (alu_stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
      chk({tag, "_vld"},  64'(reg_file_wr_req_vld),      64'd1);
      chk({tag, "_addr"}, 64'(reg_file_wr_req_pkt.addr), 64'(addr));
      chk({tag, "_data"}, 64'(reg_file_wr_req_pkt.data), 64'(data));
   endtask

   initial begin
      int k;
      logic [4:0]  fill_addr [4];
      logic [31:0] fill_data [4];
      fill_addr[0] = 5'd10; fill_addr[1] = 5'd11; fill_addr[2] = 5'd12; fill_addr[3] = 5'd13;
      fill_data[0] = 32'hA0; fill_data[1] = 32'hA1; fill_data[2] = 32'hA2; fill_data[3] = 32'hA3;

      resetn = 1'b0;
      alu_wb_vld = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
      mem_wb_vld = 1'b0; mem_wb_addr = '0; mem_wb_data = '0;
      #12;
      chk("rst_vld",   64'(reg_file_wr_req_vld), 64'd0);
      chk("rst_pkt",   64'(reg_file_wr_req_pkt), 64'd0);
      chk("rst_stall", 64'(alu_stall_req),       64'd0);
      chk("rst_pend",  64'(pend_mask),           64'd0);
      chk("rst_rdy",   64'(mem_wb_rdy),          64'd1);
      resetn = 1'b1;
      tick();

      // ALU only: latency 1, then idle holds packet, then r0 write ignored.
      alu_wb_vld = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEADBEEF;
      tick();
      alu_wb_vld = 1'b0;
      chk_wr("alu", 5'd5, 32'hDEADBEEF);
      tick();
      chk("alu_idle_vld",  64'(reg_file_wr_req_vld),      64'd0);
      chk("alu_hold_addr", 64'(reg_file_wr_req_pkt.addr), 64'd5);
      alu_wb_vld = 1'b1; alu_wb_addr = 5'd0; alu_wb_data = 32'h1;
      tick();
      alu_wb_vld = 1'b0;
      chk("alu_r0_vld", 64'(reg_file_wr_req_vld), 64'd0);

      // Memory path into empty FIFO: issues two cycles after the handshake.
      mem_wb_vld = 1'b1; mem_wb_addr = 5'd7; mem_wb_data = 32'h12345678;
      chk("mem_rdy", 64'(mem_wb_rdy), 64'd1);
      tick();
      mem_wb_vld = 1'b0;
      chk("mem_pend",   64'(pend_mask),           64'h80);
      chk("mem_n1_vld", 64'(reg_file_wr_req_vld), 64'd0);
      tick();
      chk_wr("mem", 5'd7, 32'h12345678);
      chk("mem_pend_clr", 64'(pend_mask), 64'd0);
      tick();
      chk("mem_idle_vld", 64'(reg_file_wr_req_vld), 64'd0);

      // Fill while the ALU hogs the port, then drain in order.
      for (int i = 0; i < 4; i++) begin
         alu_wb_vld = 1'b1; alu_wb_addr = 5'd1; alu_wb_data = 32'(i);
         mem_wb_vld = 1'b1; mem_wb_addr = fill_addr[i]; mem_wb_data = fill_data[i];
         tick();
      end
      mem_wb_vld = 1'b0;
      chk("fill_rdy",  64'(mem_wb_rdy), 64'd0);
      chk("fill_pend", 64'(pend_mask),  64'h3C00);
      chk_wr("fill_alu", 5'd1, 32'd3);
      alu_wb_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_wr($sformatf("drain%0d", i), fill_addr[i], fill_data[i]);
         chk($sformatf("drain%0d_rdy", i), 64'(mem_wb_rdy), 64'd1);
      end
      tick();
      chk("drain_done_vld",  64'(reg_file_wr_req_vld), 64'd0);
      chk("drain_done_pend", 64'(pend_mask),           64'd0);

      // Starvation: ALU busy every cycle while one entry waits.
      alu_wb_vld = 1'b1; alu_wb_addr = 5'd3; alu_wb_data = 32'h33;
      mem_wb_vld = 1'b1; mem_wb_addr = 5'd9; mem_wb_data = 32'h99;
      tick();
      mem_wb_vld = 1'b0;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (alu_stall_req) begin
            k = c;
            break;
         end
      end
      chk("starve_cycles", 64'(k), 64'd8);
      chk("starve_pend",   64'(pend_mask), 64'h200);
      chk_wr("starve_alu", 5'd3, 32'h33);
      alu_wb_vld = 1'b0;
      tick();
      chk("stall_pulse", 64'(alu_stall_req), 64'd0);
      chk_wr("starve_pop", 5'd9, 32'h99);
      chk("starve_pend_clr", 64'(pend_mask), 64'd0);

      // Memory handshake to r0 completes but is dropped.
      mem_wb_vld = 1'b1; mem_wb_addr = 5'd0; mem_wb_data = 32'h5;
      chk("r0_rdy", 64'(mem_wb_rdy), 64'd1);
      tick();
      mem_wb_vld = 1'b0;
      chk("r0_pend", 64'(pend_mask), 64'd0);
      tick();
      chk("r0_vld", 64'(reg_file_wr_req_vld), 64'd0);

      // Reset mid-operation discards queued entries.
      for (int i = 0; i < 3; i++) begin
         alu_wb_vld = 1'b1; alu_wb_addr = 5'd2; alu_wb_data = 32'h22;
         mem_wb_vld = 1'b1; mem_wb_addr = 5'(20 + i); mem_wb_data = 32'(i);
         tick();
      end
      mem_wb_vld = 1'b0;
      chk("prerst_pend", 64'(pend_mask),           64'h700000);
      chk("prerst_vld",  64'(reg_file_wr_req_vld), 64'd1);
      #1;
      resetn = 1'b0;
      #1;
      chk("midrst_vld",  64'(reg_file_wr_req_vld), 64'd0);
      chk("midrst_pend", 64'(pend_mask),           64'd0);
      chk("midrst_rdy",  64'(mem_wb_rdy),          64'd1);
      alu_wb_vld = 1'b0;
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("postrst%0d_vld", i), 64'(reg_file_wr_req_vld), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
